// File: rtl/cu_sched.sv
// In-order, single-issue scheduler for ALU/MUL/SHF units that share one
// register-file write port; stalls on RAW hazards against pending write-backs.
module cu_sched #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int OP_WIDTH      = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ins_valid,
  output logic                     ins_ready,
  input  logic [1:0]               ins_unit,
  input  logic [OP_WIDTH-1:0]      ins_op,
  input  logic [ADDRESS_WIDTH-1:0] ins_rd,
  input  logic [ADDRESS_WIDTH-1:0] ins_rx,
  input  logic [ADDRESS_WIDTH-1:0] ins_ry,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  output logic                     ps_alu_en,
  output logic                     ps_mul_en,
  output logic                     ps_shf_en,
  output logic [OP_WIDTH-1:0]      cu_op,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  output logic [2:0]               ps_xb_w_cuEn,
  output logic                     busy,
  input  logic                     halt,
  output logic                     err_unit
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] UNIT_ALU = 2'b00;
  localparam logic [1:0] UNIT_MUL = 2'b01;
  localparam logic [1:0] UNIT_SHF = 2'b10;
  localparam logic [1:0] UNIT_RSV = 2'b11;

  typedef struct packed {
    logic [1:0]               unit;
    logic [OP_WIDTH-1:0]      op;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [ADDRESS_WIDTH-1:0] rx;
    logic [ADDRESS_WIDTH-1:0] ry;
  } entry_t;

  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [2:0]               src;
  } wb_t;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  // wb0 drives the write port this cycle; wb1 holds a MUL result one cycle out.
  wb_t                wb0_q, wb0_d;
  wb_t                wb1_q, wb1_d;
  entry_t             fifo_q [FIFO_DEPTH];

  entry_t head;
  entry_t in_entry;
  logic   head_valid;
  logic   is_rsv;
  logic   raw_hazard;
  logic   port_block;
  logic   issue;
  logic   discard;
  logic   pop;
  logic   push;

  assign in_entry   = {ins_unit, ins_op, ins_rd, ins_rx, ins_ry};
  assign head       = fifo_q[rd_ptr_q];
  assign head_valid = (state_q != IDLE);
  assign is_rsv     = (head.unit == UNIT_RSV);

  assign raw_hazard = (wb0_q.valid && (head.rx == wb0_q.rd || head.ry == wb0_q.rd)) ||
                      (wb1_q.valid && (head.rx == wb1_q.rd || head.ry == wb1_q.rd));
  // A MUL issued last cycle owns the write port next cycle.
  assign port_block = wb1_q.valid && (head.unit == UNIT_ALU || head.unit == UNIT_SHF);

  assign issue   = head_valid && !is_rsv && !halt && !raw_hazard && !port_block;
  assign discard = head_valid && is_rsv && !halt;
  assign pop     = issue || discard;

  assign ins_ready = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
  assign push      = ins_valid && ins_ready;

  assign busy         = (count_q != '0) || wb0_q.valid || wb1_q.valid;
  assign err_unit     = discard;
  assign ps_xb_w_cuEn = wb0_q.valid ? wb0_q.src : 3'b000;
  assign ps_xb_wadd   = wb0_q.valid ? wb0_q.rd : '0;

  always_comb begin
    ps_alu_en   = 1'b0;
    ps_mul_en   = 1'b0;
    ps_shf_en   = 1'b0;
    cu_op       = '0;
    ps_xb_raddx = '0;
    ps_xb_raddy = '0;
    wb1_d       = '0;
    wb0_d       = wb1_q;
    if (issue) begin
      cu_op       = head.op;
      ps_xb_raddx = head.rx;
      ps_xb_raddy = head.ry;
      unique case (head.unit)
        UNIT_ALU: begin
          ps_alu_en = 1'b1;
          wb0_d     = '{valid: 1'b1, rd: head.rd, src: 3'b001};
        end
        UNIT_MUL: begin
          ps_mul_en = 1'b1;
          wb1_d     = '{valid: 1'b1, rd: head.rd, src: 3'b010};
        end
        UNIT_SHF: begin
          ps_shf_en = 1'b1;
          wb0_d     = '{valid: 1'b1, rd: head.rd, src: 3'b100};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    state_d  = state_q;
    if (count_d == '0) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = pop ? RUN : STALL;
        STALL:   state_d = pop ? RUN : STALL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wb0_q    <= '0;
      wb1_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wb0_q    <= wb0_d;
      wb1_q    <= wb1_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule

// File: doc/cu_sched.md
CU_SCHED -- requirements
Module: cu_sched

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, register-file address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction queue depth (power of two, >=2).
REQ-003 SHALL have parameter OP_WIDTH, default 6, unit-specific control field width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-006 SHALL have port ins_valid, input, 1, instruction offered.
REQ-007 SHALL have port ins_ready, output, 1, queue can accept an instruction (not full).
REQ-008 SHALL have port ins_unit, input, 2, unit select: 00 ALU, 01 MUL, 10 SHF, 11 reserved.
REQ-009 SHALL have port ins_op, input, OP_WIDTH, control field passed to the selected unit.
REQ-010 SHALL have ports ins_rd, ins_rx, ins_ry, input, ADDRESS_WIDTH each: destination, X source and Y source.
REQ-011 SHALL have ports ps_xb_raddx, ps_xb_raddy, output, ADDRESS_WIDTH each: operand read addresses.
REQ-012 SHALL have ports ps_alu_en, ps_mul_en, ps_shf_en, output, 1 each: unit issue strobes.
REQ-013 SHALL have port cu_op, output, OP_WIDTH: control field of the issued instruction.
REQ-014 SHALL have port ps_xb_wadd, output, ADDRESS_WIDTH: write-back address.
REQ-015 SHALL have port ps_xb_w_cuEn, output, 3: one-hot write-back source, {SHF,MUL,ALU}; 000 means no write.
REQ-016 SHALL have ports busy and halt: busy, output, 1, queue non-empty or write pending; halt, input, 1, stop issuing.
REQ-017 SHALL have port err_unit, output, 1: one-cycle pulse when a reserved-unit instruction is discarded.

Function
REQ-018 SHALL accept an instruction on the rising edge when ins_valid and ins_ready are both 1; ins_ready = (count < FIFO_DEPTH).
REQ-019 SHALL keep ins_ready at 1 when full and an issue pops in the same cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-020 SHALL use FSM states IDLE (queue empty), RUN (head issuable), STALL (head blocked by hazard or halt).
REQ-021 SHALL issue the head combinationally in cycle N: drive raddx/raddy, the unit enable and cu_op, and pop the head at the end of N.
REQ-022 SHALL give ALU/SHF write-back latency L=1 and MUL L=2: ps_xb_w_cuEn/ps_xb_wadd asserted during exactly cycle N+L.
REQ-023 SHALL implement write-back as a 2-stage shift register holding {valid, rd, src}.
REQ-024 SHALL block an ALU/SHF head in cycle N if a MUL was issued in N-1 (single write port).
REQ-025 SHALL block the head while ins_rx or ins_ry equals the rd of any write-back still pending at cycle N or later; no forwarding.
REQ-026 SHALL not block on WAW separately; REQ-024 guarantees in-order writes.
REQ-027 SHALL, while halt=1, issue nothing, keep draining pending write-backs and keep accepting into the queue.
REQ-028 SHALL drive unit enables, cu_op and raddx/raddy to 0 in any cycle with no issue.
REQ-029 SHALL pop a head with ins_unit=11 without issuing and pulse err_unit in that cycle.
REQ-030 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with count width log2(FIFO_DEPTH)+1.

Reset
REQ-031 SHALL, on reset, immediately clear: FIFO empty, FSM IDLE, write-back stages invalid, all enables 0, ps_xb_w_cuEn 000, busy 0, err_unit 0, ins_ready 1.
REQ-032 SHALL, on reset asserted mid-operation, cancel in-flight write-backs; no write enable asserts after reset.

Verification
REQ-033 Bench SHALL cover: push ALU rd=3,rx=1,ry=2 into empty queue -> issue next cycle with ps_alu_en=1, raddx=1, raddy=2; one cycle later w_cuEn=001, wadd=3.
REQ-034 Bench SHALL cover: MUL rd=5, then ALU rd=6 with independent sources -> ALU stalls one cycle; w_cuEn=010 then 001 in consecutive cycles, wadds 5 then 6.
REQ-035 Bench SHALL cover: MUL rd=4, then SHF rx=4 -> SHF issues exactly 3 cycles after MUL (N+3).
REQ-036 Bench SHALL cover: 4 pushes with halt=1 -> ins_ready=0 after the 4th; halt released -> one issue per cycle, and the 5th push accepted in the first issue cycle.
REQ-037 Bench SHALL cover: reset during cycle N+1 after a MUL issue -> w_cuEn stays 000, busy=0, queue empty.
REQ-038 Bench SHALL cover: ins_unit=11 pushed -> err_unit pulses once, no enables assert, following instruction issues next cycle.
